mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
Multi-cycle MIPS control unit. It sequences each instruction through check, fetch, decode, execute, memory and write-back states over a shared, handshaked memory port. It also provides N-instruction debug stepping, a PC breakpoint and a memory-timeout error. It drives the multi-cycle datapath, which holds PC, IR, ALU and register file, using the shared MIPS define-header encodings (PC_*, EXE_*, WB_*).

Parameters:
STEP_W, 8, width of the step-count input and the internal step counter
MEM_WAIT_MAX, 15, cycles allowed without mem_ack in IF/MEM before the bus error; 0 disables the timeout
WAIT_W, 4, wait-counter width; must hold MEM_WAIT_MAX

Ports:
clk  in  1  main clock
rst  in  1  synchronous reset, active-high
inst  in  32  IR contents, valid from ID onward
pc  in  32  current PC register value
mem_ack  in  1  memory completes the current read/write this cycle
debug_en  in  1  step mode enable
debug_step  in  1  step request, level input, rising edge detected internally
debug_step_n  in  STEP_W  instructions per step request; 0 is treated as 1
bp_valid  in  1  breakpoint armed
bp_addr  in  32  breakpoint PC
state  out  3  current state, for debug display
mem_addr_src  out  1  0 = PC, 1 = ALU result
ir_wen, pc_wen  out  1  IR and PC write enables
pc_src  out  3  PC source (PC_NEXT/PC_JUMP/PC_JR/PC_BEQ/PC_BNE)
imm_ext  out  1  1 = sign-extend immediate
exe_a_src, exe_b_src  out  2  ALU operand sources
exe_alu_oper  out  4  ALU operation
mem_ren, mem_wen  out  1  memory read/write strobes
wb_addr_src  out  2  write-back register address source
wb_data_src  out  1  0 = ALU, 1 = memory data
wb_wen  out  1  register write enable
inst_done  out  1  one-cycle pulse in an instruction's final cycle
halted  out  1  state == HALT
unrecognized  out  1  sticky: illegal instruction
bus_err  out  1  sticky: memory timeout

Behaviour:
- States: CHK=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6, ERR=7.
- All outputs are a Moore/Mealy function of state and inst. Default for every output is 0; default pc_src=PC_NEXT and exe_*_src=RS/RT.
- On rst: state<=CHK, step_left<=0, wait_cnt<=0, step_prev<=0, unrecognized<=0, bus_err<=0.
- CHK (1 cycle, no strobes):
  - bp_hit = bp_valid && pc==bp_addr.
  - If (debug_en && step_left==0) || bp_hit, go to HALT; else go to IF.
- HALT:
  - On a debug_step rising edge, go to IF. If debug_en, load step_left = max(debug_step_n, 1). The breakpoint is not rechecked, so execution resumes past the breakpoint.
  - Else if !debug_en && !bp_hit, go to IF.
  - Else stay in HALT.
  - Step edges outside HALT are ignored.
- IF:
  - mem_ren=1, mem_addr_src=0.
  - On mem_ack: ir_wen=1, pc_wen=1, pc_src=PC_NEXT (PC<=PC+4), then go to ID.
- ID: decode inst.
  - J/JR: pc_wen=1, pc_src=PC_JUMP/PC_JR, inst_done=1, then go to CHK.
  - ADD/SUB/AND/OR/SLT/ADDI/ANDI/ORI/LW/SW/BEQ/BNE/JAL: go to EX.
  - Any other opcode/function: go to ERR with unrecognized<=1.
- EX:
  - R-type: alu_oper per function code, then go to WB.
  - ADDI/LW/SW: exe_b_src=IMM, imm_ext=1, ADD. ADDI goes to WB; LW/SW go to MEM.
  - ANDI/ORI: exe_b_src=IMM, imm_ext=0, AND/OR, then go to WB.
  - BEQ/BNE: exe_a_src=A_BRANCH, exe_b_src=B_BRANCH, imm_ext=1, ADD, pc_wen=1, pc_src=PC_BEQ/PC_BNE (the datapath qualifies the condition), inst_done=1, then go to CHK.
  - JAL: A_LINK/B_LINK, ADD, wb_addr_src=LINK, wb_wen=1, pc_wen=1, pc_src=PC_JUMP, inst_done=1, then go to CHK.
- MEM:
  - mem_addr_src=1. LW asserts mem_ren; SW asserts mem_wen. The ALU controls from EX are held.
  - On mem_ack: LW goes to WB; SW asserts inst_done and goes to CHK.
  - Strobes stay asserted until mem_ack.
- WB:
  - wb_wen=1. R-type uses ADDR_RD; I-type and LW use ADDR_RT. LW uses wb_data_src=MEM, others ALU.
  - inst_done=1, then go to CHK.
- Timeout:
  - wait_cnt clears on entering IF/MEM and on mem_ack.
  - It increments each IF/MEM cycle without ack.
  - If MEM_WAIT_MAX!=0 && wait_cnt==MEM_WAIT_MAX with no ack: go to ERR with bus_err<=1.
  - An ack in that same cycle wins over the timeout.
- Step counting: on inst_done with debug_en && step_left!=0, decrement step_left. step_left saturates at 0.
- ERR: all strobes and enables are 0. ERR is exited only by rst.
- Latency with zero-wait memory, including CHK:
  - J/JR: 3 cycles.
  - BEQ/BNE/JAL: 4 cycles.
  - R-type, I-type ALU and SW: 5 cycles.
  - LW: 6 cycles.

Test Plan:
1. debug_en=0, bp_valid=0, ack tied 1; run 0x20010005 (addi $1,$0,5) then 0x00221820 (add) -> states 0,1,2,3,5 each; wb_wen high in WB with ADDR_RT then ADDR_RD; inst_done every 5 cycles.
2. LW 0x8C040004 with ack delayed 3 cycles in MEM -> mem_ren and mem_addr_src=1 held 4 cycles; WB with wb_data_src=1; total 9 cycles. SW 0xAC040008 -> mem_wen, inst_done in MEM, no wb_wen.
3. Hold ack=0 in IF, MEM_WAIT_MAX=15 -> bus_err=1 and state=7 on the 16th IF cycle; stays there until rst; rst returns state=0 with bus_err=0.
4. Opcode 0xFC000000 -> ID goes to ERR, unrecognized=1, no pc_wen/wb_wen thereafter.
5. debug_en=1 after reset -> HALT; debug_step pulse with n=3 -> exactly 3 inst_done pulses then HALT; n=0 -> 1 instruction.
6. bp_valid=1, bp_addr=0x0000000C, debug_en=0 -> halts in CHK when pc=0x0C; debug_step edge -> fetch at 0x0C proceeds; J 0x08000003 back to 0x0C -> halts again.

Source files
------------

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control unit with debug stepping, PC breakpoint and memory timeout
// Sequences CHK/IF/ID/EX/MEM/WB over a shared handshaked memory port; ERR is left only through rst.
module mc_controller #(
   parameter int STEP_W       = 8,
   parameter int MEM_WAIT_MAX = 15,
   parameter int WAIT_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       inst,
   input  logic [31:0]       pc,
   input  logic              mem_ack,
   input  logic              debug_en,
   input  logic              debug_step,
   input  logic [STEP_W-1:0] debug_step_n,
   input  logic              bp_valid,
   input  logic [31:0]       bp_addr,
   output logic [2:0]        state,
   output logic              mem_addr_src,
   output logic              ir_wen,
   output logic              pc_wen,
   output logic [2:0]        pc_src,
   output logic              imm_ext,
   output logic [1:0]        exe_a_src,
   output logic [1:0]        exe_b_src,
   output logic [3:0]        exe_alu_oper,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [1:0]        wb_addr_src,
   output logic              wb_data_src,
   output logic              wb_wen,
   output logic              inst_done,
   output logic              halted,
   output logic              unrecognized,
   output logic              bus_err
);

   localparam logic [2:0] PC_NEXT = 3'd0;
   localparam logic [2:0] PC_JUMP = 3'd1;
   localparam logic [2:0] PC_JR   = 3'd2;
   localparam logic [2:0] PC_BEQ  = 3'd3;
   localparam logic [2:0] PC_BNE  = 3'd4;

   localparam logic [1:0] EXE_A_RS     = 2'd0;
   localparam logic [1:0] EXE_A_LINK   = 2'd1;
   localparam logic [1:0] EXE_A_BRANCH = 2'd2;
   localparam logic [1:0] EXE_B_RT     = 2'd0;
   localparam logic [1:0] EXE_B_IMM    = 2'd1;
   localparam logic [1:0] EXE_B_LINK   = 2'd2;
   localparam logic [1:0] EXE_B_BRANCH = 2'd3;

   localparam logic [3:0] EXE_ALU_ADD = 4'd0;
   localparam logic [3:0] EXE_ALU_SUB = 4'd1;
   localparam logic [3:0] EXE_ALU_AND = 4'd2;
   localparam logic [3:0] EXE_ALU_OR  = 4'd3;
   localparam logic [3:0] EXE_ALU_SLT = 4'd4;

   localparam logic [1:0] WB_ADDR_RD   = 2'd0;
   localparam logic [1:0] WB_ADDR_RT   = 2'd1;
   localparam logic [1:0] WB_ADDR_LINK = 2'd2;
   localparam logic       WB_DATA_ALU  = 1'b0;
   localparam logic       WB_DATA_MEM  = 1'b1;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam bit                TIMEOUT_EN = (MEM_WAIT_MAX != 0);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

   typedef enum logic [2:0] {
      S_CHK  = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EX   = 3'd3,
      S_MEM  = 3'd4,
      S_WB   = 3'd5,
      S_HALT = 3'd6,
      S_ERR  = 3'd7
   } state_t;

   state_t              state_q, state_d;
   logic [STEP_W-1:0]   step_left_q, step_left_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                step_prev_q;
   logic                unrec_q, unrec_d;
   logic                bus_err_q, bus_err_d;

   logic [5:0] op;
   logic [5:0] funct;
   logic       is_rtype, is_r_alu, is_jr, is_j, is_jal, is_beq, is_bne;
   logic       is_addi, is_andi, is_ori, is_lw, is_sw, is_exec;
   logic       step_edge, bp_hit, mem_phase, timeout;
   logic [3:0] alu_op;
   logic       alu_b_imm, alu_ext;
   logic       unused_inst;

   assign op          = inst[31:26];
   assign funct       = inst[5:0];
   assign unused_inst = ^inst[25:6];

   assign is_rtype = (op == OP_RTYPE);
   assign is_r_alu = is_rtype && (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                                  funct == FN_OR  || funct == FN_SLT);
   assign is_jr    = is_rtype && (funct == FN_JR);
   assign is_j     = (op == OP_J);
   assign is_jal   = (op == OP_JAL);
   assign is_beq   = (op == OP_BEQ);
   assign is_bne   = (op == OP_BNE);
   assign is_addi  = (op == OP_ADDI);
   assign is_andi  = (op == OP_ANDI);
   assign is_ori   = (op == OP_ORI);
   assign is_lw    = (op == OP_LW);
   assign is_sw    = (op == OP_SW);
   assign is_exec  = is_r_alu || is_addi || is_andi || is_ori || is_lw || is_sw ||
                     is_beq || is_bne || is_jal;

   assign step_edge = debug_step && !step_prev_q;
   assign bp_hit    = bp_valid && (pc == bp_addr);
   assign mem_phase = (state_q == S_IF) || (state_q == S_MEM);
   // An ack in the limit cycle completes the access instead of faulting.
   assign timeout   = TIMEOUT_EN && !mem_ack && (wait_q == WAIT_LIMIT);

   // ALU setup shared by EX and MEM, so address generation stays stable during a load/store.
   always_comb begin
      alu_op    = EXE_ALU_ADD;
      alu_b_imm = 1'b0;
      alu_ext   = 1'b0;
      if (is_r_alu) begin
         case (funct)
            FN_SUB:  alu_op = EXE_ALU_SUB;
            FN_AND:  alu_op = EXE_ALU_AND;
            FN_OR:   alu_op = EXE_ALU_OR;
            FN_SLT:  alu_op = EXE_ALU_SLT;
            default: alu_op = EXE_ALU_ADD;
         endcase
      end else if (is_addi || is_lw || is_sw) begin
         alu_b_imm = 1'b1;
         alu_ext   = 1'b1;
      end else if (is_andi) begin
         alu_op    = EXE_ALU_AND;
         alu_b_imm = 1'b1;
      end else if (is_ori) begin
         alu_op    = EXE_ALU_OR;
         alu_b_imm = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      step_left_d  = step_left_q;
      unrec_d      = unrec_q;
      bus_err_d    = bus_err_q;
      wait_d       = (mem_phase && !mem_ack) ? wait_q + 1'b1 : '0;
      mem_addr_src = 1'b0;
      ir_wen       = 1'b0;
      pc_wen       = 1'b0;
      pc_src       = PC_NEXT;
      imm_ext      = 1'b0;
      exe_a_src    = EXE_A_RS;
      exe_b_src    = EXE_B_RT;
      exe_alu_oper = EXE_ALU_ADD;
      mem_ren      = 1'b0;
      mem_wen      = 1'b0;
      wb_addr_src  = WB_ADDR_RD;
      wb_data_src  = WB_DATA_ALU;
      wb_wen       = 1'b0;
      inst_done    = 1'b0;

      case (state_q)
         S_CHK: begin
            if ((debug_en && step_left_q == '0) || bp_hit) state_d = S_HALT;
            else                                           state_d = S_IF;
         end
         S_HALT: begin
            // A step resumes without rechecking the breakpoint so execution can move past it.
            if (step_edge) begin
               state_d = S_IF;
               if (debug_en)
                  step_left_d = (debug_step_n == '0) ? STEP_W'(1) : debug_step_n;
            end else if (!debug_en && !bp_hit) begin
               state_d = S_IF;
            end
         end
         S_IF: begin
            mem_ren = 1'b1;
            if (mem_ack) begin
               ir_wen  = 1'b1;
               pc_wen  = 1'b1;
               state_d = S_ID;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               state_d   = S_ERR;
            end
         end
         S_ID: begin
            if (is_j || is_jr) begin
               pc_wen    = 1'b1;
               pc_src    = is_j ? PC_JUMP : PC_JR;
               inst_done = 1'b1;
               state_d   = S_CHK;
            end else if (is_exec) begin
               state_d = S_EX;
            end else begin
               unrec_d = 1'b1;
               state_d = S_ERR;
            end
         end
         S_EX: begin
            if (is_beq || is_bne) begin
               exe_a_src = EXE_A_BRANCH;
               exe_b_src = EXE_B_BRANCH;
               imm_ext   = 1'b1;
               pc_wen    = 1'b1;
               pc_src    = is_beq ? PC_BEQ : PC_BNE;
               inst_done = 1'b1;
               state_d   = S_CHK;
            end else if (is_jal) begin
               exe_a_src   = EXE_A_LINK;
               exe_b_src   = EXE_B_LINK;
               wb_addr_src = WB_ADDR_LINK;
               wb_wen      = 1'b1;
               pc_wen      = 1'b1;
               pc_src      = PC_JUMP;
               inst_done   = 1'b1;
               state_d     = S_CHK;
            end else begin
               exe_alu_oper = alu_op;
               exe_b_src    = alu_b_imm ? EXE_B_IMM : EXE_B_RT;
               imm_ext      = alu_ext;
               state_d      = (is_lw || is_sw) ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            mem_addr_src = 1'b1;
            exe_alu_oper = alu_op;
            exe_b_src    = alu_b_imm ? EXE_B_IMM : EXE_B_RT;
            imm_ext      = alu_ext;
            mem_ren      = is_lw;
            mem_wen      = is_sw;
            if (mem_ack) begin
               if (is_lw) begin
                  state_d = S_WB;
               end else begin
                  inst_done = 1'b1;
                  state_d   = S_CHK;
               end
            end else if (timeout) begin
               bus_err_d = 1'b1;
               state_d   = S_ERR;
            end
         end
         S_WB: begin
            wb_wen      = 1'b1;
            wb_addr_src = is_rtype ? WB_ADDR_RD : WB_ADDR_RT;
            wb_data_src = is_lw ? WB_DATA_MEM : WB_DATA_ALU;
            inst_done   = 1'b1;
            state_d     = S_CHK;
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_ERR;
         end
      endcase

      if (inst_done && debug_en && step_left_q != '0)
         step_left_d = step_left_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_CHK;
         step_left_q <= '0;
         wait_q      <= '0;
         step_prev_q <= 1'b0;
         unrec_q     <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_left_q <= step_left_d;
         wait_q      <= wait_d;
         step_prev_q <= debug_step;
         unrec_q     <= unrec_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign state        = state_q;
   assign halted       = (state_q == S_HALT);
   assign unrecognized = unrec_q;
   assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - self-checking bench for mc_controller against a per-instruction state-sequence model
module tb_mc_controller;

   localparam int ST_CHK = 0, ST_IF = 1, ST_ID = 2, ST_EX = 3, ST_MEM = 4, ST_WB = 5, ST_HALT = 6, ST_ERR = 7;
   localparam int C_J = 0, C_BR = 1, C_JAL = 2, C_R = 3, C_I = 4, C_LW = 5, C_SW = 6;
   localparam int PC_NEXT = 0, PC_JUMP = 1, PC_JR = 2, PC_BEQ = 3, PC_BNE = 4;
   localparam int A_LINK = 1, A_BRANCH = 2, B_RT = 0, B_IMM = 1, B_LINK = 2, B_BRANCH = 3;
   localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_AND = 2, ALU_OR = 3, ALU_SLT = 4;
   localparam int WB_RD = 0, WB_RT = 1, WB_LINK = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst = 32'h0;
   logic [31:0] pc = 32'h0;
   logic        mem_ack = 1'b0;
   logic        debug_en = 1'b0;
   logic        debug_step = 1'b0;
   logic [7:0]  debug_step_n = 8'd1;
   logic        bp_valid = 1'b0;
   logic [31:0] bp_addr = 32'h0;
   logic [2:0]  state;
   logic        mem_addr_src, ir_wen, pc_wen, imm_ext, mem_ren, mem_wen;
   logic [2:0]  pc_src;
   logic [1:0]  exe_a_src, exe_b_src, wb_addr_src;
   logic [3:0]  exe_alu_oper;
   logic        wb_data_src, wb_wen, inst_done, halted, unrecognized, bus_err;

   int n_checks = 0;
   int n_pass   = 0;

   mc_controller #(.STEP_W(8), .MEM_WAIT_MAX(15), .WAIT_W(4)) dut (
      .clk(clk), .rst(rst), .inst(inst), .pc(pc), .mem_ack(mem_ack),
      .debug_en(debug_en), .debug_step(debug_step), .debug_step_n(debug_step_n),
      .bp_valid(bp_valid), .bp_addr(bp_addr), .state(state),
      .mem_addr_src(mem_addr_src), .ir_wen(ir_wen), .pc_wen(pc_wen), .pc_src(pc_src),
      .imm_ext(imm_ext), .exe_a_src(exe_a_src), .exe_b_src(exe_b_src),
      .exe_alu_oper(exe_alu_oper), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .wb_addr_src(wb_addr_src), .wb_data_src(wb_data_src), .wb_wen(wb_wen),
      .inst_done(inst_done), .halted(halted), .unrecognized(unrecognized), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else             n_pass++;
   endtask

   function automatic int classify(input logic [31:0] ins);
      case (ins[31:26])
         6'h00:        classify = (ins[5:0] == 6'h08) ? C_J : C_R;
         6'h02:        classify = C_J;
         6'h03:        classify = C_JAL;
         6'h04, 6'h05: classify = C_BR;
         6'h23:        classify = C_LW;
         6'h2B:        classify = C_SW;
         default:      classify = C_I;
      endcase
   endfunction

   function automatic int exp_alu(input logic [31:0] ins);
      logic [5:0] fn;
      fn = ins[5:0];
      case (ins[31:26])
         6'h00: case (fn)
                   6'h22:   exp_alu = ALU_SUB;
                   6'h24:   exp_alu = ALU_AND;
                   6'h25:   exp_alu = ALU_OR;
                   6'h2A:   exp_alu = ALU_SLT;
                   default: exp_alu = ALU_ADD;
                endcase
         6'h0C:   exp_alu = ALU_AND;
         6'h0D:   exp_alu = ALU_OR;
         default: exp_alu = ALU_ADD;
      endcase
   endfunction

   function automatic logic [31:0] gen_inst();
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic [5:0]  fn;
      rs  = 5'($urandom);
      rt  = 5'($urandom);
      rd  = 5'($urandom);
      imm = 16'($urandom);
      tgt = 26'($urandom);
      case ($urandom_range(0, 4))
         0:       fn = 6'h20;
         1:       fn = 6'h22;
         2:       fn = 6'h24;
         3:       fn = 6'h25;
         default: fn = 6'h2A;
      endcase
      case ($urandom_range(0, 10))
         0:       gen_inst = {6'h02, tgt};
         1:       gen_inst = {6'h00, rs, 15'h0, 6'h08};
         2:       gen_inst = {6'h04, rs, rt, imm};
         3:       gen_inst = {6'h05, rs, rt, imm};
         4:       gen_inst = {6'h03, tgt};
         5:       gen_inst = {6'h00, rs, rt, rd, 5'h0, fn};
         6:       gen_inst = {6'h08, rs, rt, imm};
         7:       gen_inst = {6'h0C, rs, rt, imm};
         8:       gen_inst = {6'h0D, rs, rt, imm};
         9:       gen_inst = {6'h23, rs, rt, imm};
         default: gen_inst = {6'h2B, rs, rt, imm};
      endcase
   endfunction

   // Expected state sequence follows from the instruction class and the memory wait counts;
   // d1/d2 are cycles without ack before the ack cycle in IF/MEM.
   task automatic run_instr(input logic [31:0] ins, input int d1, input int d2, input bit from_if);
      int          cls, st, if_n, mem_n;
      int          seq[$];
      bit          last, ack_now;
      logic [31:0] pc4;
      cls = classify(ins);
      if (!from_if) seq.push_back(ST_CHK);
      for (int i = 0; i <= d1; i++) seq.push_back(ST_IF);
      seq.push_back(ST_ID);
      if (cls != C_J) seq.push_back(ST_EX);
      if (cls == C_LW || cls == C_SW) for (int i = 0; i <= d2; i++) seq.push_back(ST_MEM);
      if (cls == C_R || cls == C_I || cls == C_LW) seq.push_back(ST_WB);
      inst  = ins;
      if_n  = 0;
      mem_n = 0;
      foreach (seq[k]) begin
         st      = seq[k];
         last    = (k == seq.size() - 1);
         ack_now = (st == ST_IF && if_n == d1) || (st == ST_MEM && mem_n == d2);
         mem_ack = ack_now;
         #1;
         check("state", 32'(state), 32'(st));
         check("inst_done", 32'(inst_done), 32'(last));
         check("mem_ren", 32'(mem_ren), 32'(st == ST_IF || (st == ST_MEM && cls == C_LW)));
         check("mem_wen", 32'(mem_wen), 32'(st == ST_MEM && cls == C_SW));
         check("wb_wen", 32'(wb_wen), 32'(st == ST_WB || (st == ST_EX && cls == C_JAL)));
         check("pc_wen", 32'(pc_wen), 32'((st == ST_IF && ack_now) || (st == ST_ID && cls == C_J) ||
                                          (st == ST_EX && (cls == C_BR || cls == C_JAL))));
         if (st == ST_IF) begin
            check("ir_wen", 32'(ir_wen), 32'(ack_now));
            check("if_addr_src", 32'(mem_addr_src), 32'd0);
            if (ack_now) check("if_pc_src", 32'(pc_src), 32'(PC_NEXT));
         end
         if (st == ST_ID && cls == C_J)
            check("id_pc_src", 32'(pc_src), 32'((ins[31:26] == 6'h02) ? PC_JUMP : PC_JR));
         if (st == ST_EX) begin
            if (cls == C_BR) begin
               check("br_pc_src", 32'(pc_src), 32'((ins[31:26] == 6'h04) ? PC_BEQ : PC_BNE));
               check("br_a_src", 32'(exe_a_src), 32'(A_BRANCH));
               check("br_b_src", 32'(exe_b_src), 32'(B_BRANCH));
               check("br_imm_ext", 32'(imm_ext), 32'd1);
            end else if (cls == C_JAL) begin
               check("jal_pc_src", 32'(pc_src), 32'(PC_JUMP));
               check("jal_wb_addr", 32'(wb_addr_src), 32'(WB_LINK));
               check("jal_a_src", 32'(exe_a_src), 32'(A_LINK));
               check("jal_b_src", 32'(exe_b_src), 32'(B_LINK));
            end else begin
               check("ex_alu", 32'(exe_alu_oper), 32'(exp_alu(ins)));
               check("ex_b_src", 32'(exe_b_src), 32'((cls == C_R) ? B_RT : B_IMM));
               check("ex_imm_ext", 32'(imm_ext),
                     32'(ins[31:26] == 6'h08 || cls == C_LW || cls == C_SW));
            end
         end
         if (st == ST_MEM) begin
            check("mem_addr_src", 32'(mem_addr_src), 32'd1);
            check("mem_alu_held", 32'(exe_alu_oper), 32'(ALU_ADD));
            check("mem_b_held", 32'(exe_b_src), 32'(B_IMM));
         end
         if (st == ST_WB) begin
            check("wb_addr_src", 32'(wb_addr_src), 32'((cls == C_R) ? WB_RD : WB_RT));
            check("wb_data_src", 32'(wb_data_src), 32'(cls == C_LW));
         end
         if (st == ST_IF)  if_n++;
         if (st == ST_MEM) mem_n++;
         @(negedge clk);
      end
      mem_ack = 1'b0;
      pc4 = pc + 32'd4;
      if (ins[31:26] == 6'h02 || ins[31:26] == 6'h03) pc = {pc4[31:28], ins[25:0], 2'b00};
      else                                            pc = pc4;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      mem_ack    = 1'b0;
      debug_step = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      pc  = 32'h0;
   endtask

   task automatic pulse_step(input int n);
      debug_step_n = 8'(n);
      debug_step   = 1'b1;
      @(negedge clk);
      debug_step = 1'b0;
      #1;
      check("step_to_if", 32'(state), 32'(ST_IF));
   endtask

   task automatic expect_chk_then_halt(input string tag);
      #1;
      check({tag, "_chk"}, 32'(state), 32'(ST_CHK));
      @(negedge clk);
      #1;
      check({tag, "_halt"}, 32'(state), 32'(ST_HALT));
      check({tag, "_halted"}, 32'(halted), 32'd1);
   endtask

   task automatic step_round(input int req, input int n_exp);
      pulse_step(req);
      for (int i = 0; i < n_exp; i++)
         run_instr(gen_inst(), $urandom_range(0, 2), $urandom_range(0, 2), i == 0);
      expect_chk_then_halt("step_end");
   endtask

   initial begin
      do_reset();
      #1;
      check("rst_state", 32'(state), 32'(ST_CHK));
      check("rst_bus_err", 32'(bus_err), 32'd0);
      check("rst_unrec", 32'(unrecognized), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_mem_ren", 32'(mem_ren), 32'd0);
      check("rst_pc_wen", 32'(pc_wen), 32'd0);

      run_instr(32'h20010005, 0, 0, 0);
      run_instr(32'h00221820, 0, 0, 0);
      run_instr(32'h8C040004, 0, 3, 0);
      run_instr(32'hAC040008, 0, 0, 0);
      run_instr(32'h20010005, 15, 0, 0);
      run_instr(32'h8C040004, 0, 15, 0);

      for (int i = 0; i < 40; i++)
         run_instr(gen_inst(), $urandom_range(0, 3), $urandom_range(0, 3), 0);

      do_reset();
      #1;
      check("to_chk", 32'(state), 32'(ST_CHK));
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         #1;
         check("to_if", 32'(state), 32'(ST_IF));
         check("to_no_err", 32'(bus_err), 32'd0);
         @(negedge clk);
      end
      mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("to_err_state", 32'(state), 32'(ST_ERR));
         check("to_bus_err", 32'(bus_err), 32'd1);
         check("to_err_ren", 32'(mem_ren), 32'd0);
         @(negedge clk);
      end
      do_reset();
      #1;
      check("to_rst_state", 32'(state), 32'(ST_CHK));
      check("to_rst_bus_err", 32'(bus_err), 32'd0);

      inst    = 32'hFC000000;
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      check("ill_if", 32'(state), 32'(ST_IF));
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      check("ill_id", 32'(state), 32'(ST_ID));
      check("ill_unrec_pre", 32'(unrecognized), 32'd0);
      @(negedge clk);
      mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("ill_err", 32'(state), 32'(ST_ERR));
         check("ill_unrec", 32'(unrecognized), 32'd1);
         check("ill_pc_wen", 32'(pc_wen), 32'd0);
         check("ill_wb_wen", 32'(wb_wen), 32'd0);
         @(negedge clk);
      end
      do_reset();
      #1;
      check("ill_rst_unrec", 32'(unrecognized), 32'd0);

      debug_en = 1'b1;
      do_reset();
      expect_chk_then_halt("dbg_start");
      @(negedge clk);
      #1;
      check("dbg_hold", 32'(state), 32'(ST_HALT));
      step_round(3, 3);
      step_round(0, 1);
      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(1, 4);
         step_round(n, n);
      end
      debug_en = 1'b0;

      bp_valid = 1'b1;
      bp_addr  = 32'h0000000C;
      do_reset();
      run_instr(32'h20010005, 0, 0, 0);
      run_instr(32'h34220007, 1, 0, 0);
      run_instr(32'hAC040008, 0, 1, 0);
      check("bp_pc_model", pc, 32'h0000000C);
      expect_chk_then_halt("bp_hit");
      @(negedge clk);
      #1;
      check("bp_hold", 32'(state), 32'(ST_HALT));
      pulse_step(1);
      run_instr(32'h08000003, 0, 0, 1);
      expect_chk_then_halt("bp_again");
      bp_valid = 1'b0;
      @(negedge clk);
      #1;
      check("bp_disarm_if", 32'(state), 32'(ST_IF));
      run_instr(32'h20010005, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
